// File: rtl/arb_req_agent.sv
// Requester-side agent for a one-hot fixed-priority arbiter: pending counters, grant checks.
// Optional starvation watchdog built when ARB_REQ_STARVE_EN is defined.
module arb_req_agent #(
   parameter int unsigned N          = 32,
   parameter int unsigned CNT_W      = 4,
   parameter int unsigned STARVE_MAX = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] push_i,
   input  logic [N-1:0] gnt_i,
   output logic [N-1:0] req_o,
   output logic [N-1:0] served_o,
   output logic [N-1:0] ovf_o,
   output logic [1:0]   err_o,
   output logic [N-1:0] starve_o
);

   if (N < 1 || STARVE_MAX < 1) begin : g_bad_param
      $error("arb_req_agent: N and STARVE_MAX must be >= 1");
   end

   logic [CNT_W-1:0] pend_q [N];
   logic [CNT_W-1:0] pend_d [N];
   logic [N-1:0]     served_q, served_d;
   logic [N-1:0]     ovf_q, ovf_d;
   logic [1:0]       err_q, err_d;

   logic             gnt_any;
   logic             gnt_multi;
   logic             gnt_valid;
   logic             gnt_spur;
   logic [N-1:0]     gnt_vld;

   // req_o comes straight from registered counters: no input-to-output path.
   always_comb begin
      req_o = '0;
      for (int i = 0; i < N; i++) begin
         req_o[i] = |pend_q[i];
      end
   end

   // x & (x-1) clears the lowest set bit; anything left means multi-hot.
   always_comb begin
      gnt_any   = |gnt_i;
      gnt_multi = |(gnt_i & (gnt_i - 1'b1));
      gnt_valid = gnt_any && !gnt_multi && |(gnt_i & req_o);
      gnt_spur  = gnt_any && !gnt_multi && !gnt_valid;
      gnt_vld   = gnt_valid ? gnt_i : '0;
   end

   always_comb begin
      served_d = gnt_vld;
      ovf_d    = ovf_q;
      err_d    = err_q | {gnt_multi, gnt_spur};
      for (int i = 0; i < N; i++) begin
         pend_d[i] = pend_q[i];
         case ({push_i[i], gnt_vld[i]})
            2'b10: begin
               if (&pend_q[i]) begin
                  ovf_d[i] = 1'b1;
               end else begin
                  pend_d[i] = pend_q[i] + 1'b1;
               end
            end
            2'b01:   pend_d[i] = pend_q[i] - 1'b1;
            default: pend_d[i] = pend_q[i];
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) begin
            pend_q[i] <= '0;
         end
         served_q <= '0;
         ovf_q    <= '0;
         err_q    <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            pend_q[i] <= pend_d[i];
         end
         served_q <= served_d;
         ovf_q    <= ovf_d;
         err_q    <= err_d;
      end
   end

   assign served_o = served_q;
   assign ovf_o    = ovf_q;
   assign err_o    = err_q;

`ifdef ARB_REQ_STARVE_EN
   localparam int unsigned SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] StarveMax = SW'(STARVE_MAX);

   logic [SW-1:0] stv_q [N];
   logic [SW-1:0] stv_d [N];

   always_comb begin
      starve_o = '0;
      for (int i = 0; i < N; i++) begin
         if (!req_o[i] || gnt_vld[i]) begin
            stv_d[i] = '0;
         end else if (stv_q[i] == StarveMax) begin
            stv_d[i] = stv_q[i];
         end else begin
            stv_d[i] = stv_q[i] + 1'b1;
         end
         starve_o[i] = (stv_q[i] == StarveMax);
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (!reset) begin
            stv_q[i] <= '0;
         end else begin
            stv_q[i] <= stv_d[i];
         end
      end
   end
`else
   assign starve_o = '0;
`endif

endmodule

// File: tb/tb_arb_req_agent.sv
// Vector-table bench for arb_req_agent (N=4, CNT_W=2, STARVE_MAX=8) with an expectation queue.
module tb_arb_req_agent;

   localparam int unsigned N = 4;
`ifdef ARB_REQ_STARVE_EN
   localparam logic [3:0] Stv = 4'h8;
`else
   localparam logic [3:0] Stv = 4'h0;
`endif

   typedef struct {
      logic       rst_n;
      logic [3:0] push;
      logic [3:0] gnt;
      logic [3:0] req;
      logic [3:0] served;
      logic [3:0] ovf;
      logic [1:0] err;
      logic [3:0] starve;
   } vec_t;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] push_i;
   logic [N-1:0] gnt_i;
   logic [N-1:0] req_o;
   logic [N-1:0] served_o;
   logic [N-1:0] ovf_o;
   logic [1:0]   err_o;
   logic [N-1:0] starve_o;

   int   n_run  = 0;
   int   n_fail = 0;
   vec_t vecs[$];
   vec_t sb[$];

   arb_req_agent #(.N(N), .CNT_W(2), .STARVE_MAX(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .push_i   (push_i),
      .gnt_i    (gnt_i),
      .req_o    (req_o),
      .served_o (served_o),
      .ovf_o    (ovf_o),
      .err_o    (err_o),
      .starve_o (starve_o)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic [3:0] p, input logic [3:0] g,
                               input logic [3:0] rq, input logic [3:0] sv, input logic [3:0] ov,
                               input logic [1:0] er, input logic [3:0] st);
      vec_t v;
      v.rst_n = r; v.push = p; v.gnt = g; v.req = rq;
      v.served = sv; v.ovf = ov; v.err = er; v.starve = st;
      return v;
   endfunction

   task automatic cmp(input string name, input int idx, input logic [3:0] act,
                      input logic [3:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL step %0d %s: got %h expected %h", idx, name, act, exp);
      end
   endtask

   task automatic step(input vec_t v, input int idx);
      vec_t e;
      @(negedge clk);
      reset  = v.rst_n;
      push_i = v.push;
      gnt_i  = v.gnt;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      cmp("req_o", idx, req_o, e.req);
      cmp("served_o", idx, served_o, e.served);
      cmp("ovf_o", idx, ovf_o, e.ovf);
      cmp("err_o", idx, {2'b00, err_o}, {2'b00, e.err});
      cmp("starve_o", idx, starve_o, e.starve);
   endtask

   initial begin
      reset  = 1'b0;
      push_i = '0;
      gnt_i  = '0;

      // reset held with pushes, then released
      vecs.push_back(mk(0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 2'b00, 4'h0));
      vecs.push_back(mk(0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 2'b00, 4'h0));
      vecs.push_back(mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'b00, 4'h0));
      // client 2: three pushes, three grants
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(1, 4'h4, 4'h0, 4'h4, 4'h0, 4'h0, 2'b00, 4'h0));
      vecs.push_back(mk(1, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 2'b00, 4'h0));
      vecs.push_back(mk(1, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 2'b00, 4'h0));
      vecs.push_back(mk(1, 4'h0, 4'h4, 4'h0, 4'h4, 4'h0, 2'b00, 4'h0));
      vecs.push_back(mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'b00, 4'h0));
      // client 0 saturates at 3, fourth push overflows
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(1, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 2'b00, 4'h0));
      vecs.push_back(mk(1, 4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 2'b00, 4'h0));
      vecs.push_back(mk(1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 2'b00, 4'h0));
      vecs.push_back(mk(1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 2'b00, 4'h0));
      vecs.push_back(mk(1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h1, 2'b00, 4'h0));
      // simultaneous push and grant on client 1
      vecs.push_back(mk(1, 4'h2, 4'h0, 4'h2, 4'h0, 4'h1, 2'b00, 4'h0));
      vecs.push_back(mk(1, 4'h2, 4'h2, 4'h2, 4'h2, 4'h1, 2'b00, 4'h0));
      // spurious then multi-hot grants
      vecs.push_back(mk(1, 4'h0, 4'h8, 4'h2, 4'h0, 4'h1, 2'b01, 4'h0));
      vecs.push_back(mk(1, 4'h1, 4'h0, 4'h3, 4'h0, 4'h1, 2'b01, 4'h0));
      vecs.push_back(mk(1, 4'h0, 4'h3, 4'h3, 4'h0, 4'h1, 2'b11, 4'h0));
      vecs.push_back(mk(1, 4'h0, 4'h2, 4'h1, 4'h2, 4'h1, 2'b11, 4'h0));
      vecs.push_back(mk(1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h1, 2'b11, 4'h0));
      vecs.push_back(mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 2'b11, 4'h0));
      // multi-hot grant still accepts the push
      vecs.push_back(mk(1, 4'h8, 4'h5, 4'h8, 4'h0, 4'h1, 2'b11, 4'h0));

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i], i);
      end

      // starvation: client 3 waits eight cycles, then is granted
      for (int i = 1; i <= 9; i++) begin
         step(mk(1, 4'h0, 4'h0, 4'h8, 4'h0, 4'h1, 2'b11, (i >= 8) ? Stv : 4'h0), 100 + i);
      end
      step(mk(1, 4'h0, 4'h8, 4'h0, 4'h8, 4'h1, 2'b11, 4'h0), 110);

      // mid-stream reset beats push and grant, clears sticky flags
      step(mk(1, 4'hF, 4'h0, 4'hF, 4'h0, 4'h1, 2'b11, 4'h0), 200);
      step(mk(0, 4'hF, 4'h1, 4'h0, 4'h0, 4'h0, 2'b00, 4'h0), 201);
      step(mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'b00, 4'h0), 202);

      if (sb.size() != 0) begin
         n_run++;
         n_fail++;
         $display("FAIL scoreboard: %0d entries left expected 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/arb_req_agent.md
# arb_req_agent

Requester-side companion to the single-cycle fixed-priority arbiter. It collects per-client request pulses into saturating pending counters and drives the arbiter's `req` vector. It consumes the arbiter's one-hot `gnt` vector, retires one pending request per grant, and reports a registered `served` strobe to the winning client. It checks the grant for protocol violations and, optionally, watches for starvation. It sits between N client engines and one `single_cycle_arbiter` instance.

## Interface
- `N`, 32: number of clients; must be ≥ 1.
- `CNT_W`, 4: pending-counter width. Each client holds at most 2^CNT_W−1 outstanding requests.
- `STARVE_MAX`, 64: starvation threshold in cycles; must be ≥ 1. Used only when the starvation watchdog is compiled in.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `push_i`  in  N: per-client request pulse; each set bit adds one pending request that cycle.
- `gnt_i`  in  N: grant vector from the arbiter; expected to be one-hot or zero.
- `req_o`  out  N: to the arbiter. `req_o[i] = (pend[i] != 0)`, decoded from registered state with no combinational path from inputs.
- `served_o`  out  N: registered one-hot strobe; bit i is high for one cycle after a valid grant to client i.
- `ovf_o`  out  N: sticky per-client overflow flag.
- `err_o`  out  2: sticky protocol errors. Bit 0 = spurious grant; bit 1 = multi-hot grant.
- `starve_o`  out  N: per-client starvation flag. Tied to 0 when the watchdog is compiled out.

## Operation
- `pend[i]` is an unsigned CNT_W-bit counter. All counters are 0 at reset.
- Valid grant: `gnt_i` is one-hot, the set bit is k, and `req_o[k] = 1`.
- Counter update per client, each cycle:
  - `push_i[i]` and a valid grant to i: `pend[i]` unchanged.
  - Push only: `pend[i]` increments, unless it is saturated (all ones). At saturation the push is dropped and `ovf_o[i]` is set.
  - Valid grant only: `pend[i]` decrements.
- `served_o` next cycle = `gnt_i` if the grant was valid, else 0.
- Spurious grant: `gnt_i` is one-hot but the granted client has `req_o = 0`. No counter changes, `err_o[0]` is set, and `served_o` = 0.
- Multi-hot grant: more than one bit set in `gnt_i`. No grant is honoured that cycle, `err_o[1]` is set, and `served_o` = 0. Pushes that cycle are still accepted.
- `gnt_i` = 0 is legal. It has no effect beyond pushes.
- `ovf_o` and `err_o` are cleared only by reset.
- N = 1: same behaviour. The multi-hot check is constant false.

## Timing
- Reset (`reset` = 0 at an edge) clears `pend`, `served_o`, `ovf_o`, `err_o`, `starve_o`, and all starvation counters. `req_o` = 0 in the following cycle.
- Reset asserted mid-stream wins over any push or grant in the same cycle. All pending requests are discarded.
- Push-to-request latency: `push_i[i]` at edge t gives `req_o[i] = 1` from t+1.
- Grant-to-served latency: 1 cycle.
- Last-request retirement: a grant that brings `pend[i]` to 0 drops `req_o[i]` in the next cycle. The arbiter therefore never sees a stale request after the final grant.
- Throughput: one retirement per cycle across all clients, and one push per client per cycle.

## Configuration
- `ARB_REQ_STARVE_EN` defined:
  - Each client has a starvation counter of width clog2(STARVE_MAX+1).
  - The counter increments each cycle that `req_o[i] = 1` with no valid grant to i, and saturates at STARVE_MAX.
  - The counter clears on a valid grant to i, or when `req_o[i] = 0`.
  - `starve_o[i] = 1` while the counter equals STARVE_MAX. It therefore goes low the cycle after the next valid grant to i.
- `ARB_REQ_STARVE_EN` undefined: no starvation logic is built and `starve_o` is constant 0.

## Test plan
All scenarios use N=4, CNT_W=2, STARVE_MAX=8.
- Reset: hold `reset`=0 for 2 cycles with `push_i`=4'hF. Expect `req_o`, `served_o`, `ovf_o`, `err_o`, and `starve_o` all 0 after release.
- Push/grant accounting:
  - Push client 2 three times; expect `req_o`=4'h4.
  - Grant 4'h4 on three consecutive cycles; expect `served_o`=4'h4 on each following cycle.
  - Expect `req_o`=0 after the third grant.
- Saturation: push client 0 four times. Expect pend=3 and `ovf_o`=4'h1. Exactly 3 grants are then needed to clear `req_o[0]`.
- Simultaneous push and grant: with client 1 at pend=1, drive `push_i`=4'h2 and `gnt_i`=4'h2 together. Expect pend stays 1, `req_o[1]`=1, and `served_o`=4'h2.
- Protocol errors:
  - `gnt_i`=4'h8 with `req_o[3]`=0: expect `err_o`=2'b01 and `served_o`=0.
  - Then `gnt_i`=4'h3 with both clients pending: expect `err_o`=2'b11 and no counter changes.
- Starvation (macro defined): client 3 pending, no grants for 8 cycles. Expect `starve_o`=4'h8 from the 8th cycle. One grant gives `starve_o`=0 the next cycle. With the macro undefined, `starve_o` stays 0.
